// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - tagged fixed-latency memory responder for the processor/memory bus
module imem_responder #(
    parameter int MEM_LATENCY     = 8,
    parameter int MEM_WORDS       = 8192,
    parameter int MAX_OUTSTANDING = 15,
    parameter int XLEN            = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [1:0]      proc2mem_command,
    input  logic [XLEN-1:0] proc2mem_addr,
    input  logic [63:0]     proc2mem_data,
    output logic [3:0]      mem2proc_response,
    output logic [63:0]     mem2proc_data,
    output logic [3:0]      mem2proc_tag
);
    localparam logic [1:0] BUS_NONE  = 2'h0;
    localparam logic [1:0] BUS_STORE = 2'h2;
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int DEPTH  = MAX_OUTSTANDING;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DUE_W  = $clog2(MEM_LATENCY + 1);
    localparam bit BYPASS = (MEM_LATENCY == 1);

    logic [63:0]      mem [MEM_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic [63:0]      fill_data;
    logic             is_store;
    logic             accept;
    logic             push;
    logic             pop;
    logic [3:0]       free_tag;
    logic [4:0]       busy_cnt;
    logic [15:0]      busy;
    logic [15:0]      busy_nxt;
    logic             unused_addr;

    logic [3:0]       q_tag  [DEPTH];
    logic [63:0]      q_data [DEPTH];
    logic [DUE_W-1:0] q_due  [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [4:0]       count;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign word_idx    = proc2mem_addr[3 +: IDX_W];
    assign unused_addr = ^proc2mem_addr;
    assign is_store    = (proc2mem_command == BUS_STORE);
    assign fill_data   = is_store ? proc2mem_data : mem[word_idx];

    // Tag 0 means "none", so the search runs over 1..15 only.
    always_comb begin
        free_tag = '0;
        busy_cnt = '0;
        for (int i = 15; i >= 1; i--) begin
            if (!busy[i]) free_tag = 4'(i);
        end
        for (int i = 1; i < 16; i++) begin
            busy_cnt = busy_cnt + 5'(busy[i]);
        end
    end

    assign accept = reset_n && (proc2mem_command != BUS_NONE) && (free_tag != 4'd0)
                    && (busy_cnt < 5'(MAX_OUTSTANDING));
    assign mem2proc_response = accept ? free_tag : 4'd0;

    assign push = accept && !BYPASS;
    // Head leaves at countdown 1; the output register supplies the final cycle of latency.
    assign pop  = (count != 5'd0) && (q_due[head] == DUE_W'(1));

    always_comb begin
        busy_nxt = busy;
        if (mem2proc_tag != 4'd0) busy_nxt[mem2proc_tag] = 1'b0;
        if (accept) busy_nxt[free_tag] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (accept && is_store) mem[word_idx] <= proc2mem_data;
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (q_due[i] != '0) q_due[i] <= q_due[i] - DUE_W'(1);
        end
        if (push) begin
            q_tag[tail]  <= free_tag;
            q_data[tail] <= fill_data;
            q_due[tail]  <= DUE_W'(MEM_LATENCY - 1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            busy          <= '0;
            mem2proc_tag  <= '0;
            mem2proc_data <= '0;
        end else begin
            mem2proc_tag  <= '0;
            mem2proc_data <= '0;
            if (BYPASS) begin
                if (accept) begin
                    mem2proc_tag  <= free_tag;
                    mem2proc_data <= fill_data;
                end
            end else if (pop) begin
                mem2proc_tag  <= q_tag[head];
                mem2proc_data <= q_data[head];
                head          <= wrap_inc(head);
            end
            if (push) tail <= wrap_inc(tail);
            count <= count + 5'(push) - 5'(pop);
            busy  <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - table and scoreboard bench for imem_responder
module tb_imem_responder;
    localparam int XLEN  = 32;
    localparam int LAT   = 6;
    localparam int WORDS = 8192;
    localparam int MAXO  = 4;
    localparam int IDXW  = $clog2(WORDS);
    localparam logic [1:0] BUS_NONE  = 2'h0;
    localparam logic [1:0] BUS_LOAD  = 2'h1;
    localparam logic [1:0] BUS_STORE = 2'h2;
    localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DB = 64'h5555_6666_7777_8888;
    localparam logic [63:0] DC = 64'hA5A5_0000_FFFF_0123;
    localparam logic [63:0] DD = 64'hDEAD_BEEF_0000_1234;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [1:0]      cmd = BUS_NONE;
    logic [XLEN-1:0] addr = '0;
    logic [63:0]     wdata = '0;
    logic [3:0]      resp;
    logic [3:0]      ctag;
    logic [63:0]     cdata;

    always #5 clock = ~clock;

    imem_responder #(
        .MEM_LATENCY(LAT), .MEM_WORDS(WORDS), .MAX_OUTSTANDING(MAXO), .XLEN(XLEN)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .proc2mem_command(cmd),
        .proc2mem_addr(addr),
        .proc2mem_data(wdata),
        .mem2proc_response(resp),
        .mem2proc_data(cdata),
        .mem2proc_tag(ctag)
    );

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic [3:0]  resp;
    } vec_t;

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [63:0] data;
    } comp_t;

    vec_t        tbl [$];
    comp_t       sb [$];
    logic [63:0] mem_m [int];
    bit          busy_m [16];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic add_vec(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                           input logic [3:0] r);
        vec_t v;
        v.cmd = c; v.addr = a; v.data = d; v.resp = r;
        tbl.push_back(v);
    endtask

    // Called just after a negedge: drives one bus cycle, checks it, advances the model.
    task automatic run_cycle(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                             input bit use_tbl, input logic [3:0] tbl_resp);
        logic [3:0]  exp_resp;
        logic [3:0]  exp_tag;
        logic [63:0] exp_data;
        int          nbusy;
        int          idx;
        comp_t       e;
        cmd = c; addr = a; wdata = d;
        #1;
        exp_tag = '0;
        exp_data = '0;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            exp_tag = e.tag;
            exp_data = e.data;
        end
        nbusy = 0;
        for (int i = 1; i < 16; i++) nbusy += busy_m[i] ? 1 : 0;
        exp_resp = '0;
        if (c != BUS_NONE && nbusy < MAXO) begin
            for (int i = 15; i >= 1; i--) if (!busy_m[i]) exp_resp = 4'(i);
        end
        if (use_tbl) exp_resp = tbl_resp;
        check("response", 64'(resp), 64'(exp_resp));
        check("comp_tag", 64'(ctag), 64'(exp_tag));
        check("comp_data", cdata, exp_data);
        if (exp_tag != 4'd0) busy_m[exp_tag] = 1'b0;
        if (exp_resp != 4'd0) begin
            idx = int'(a[3 +: IDXW]);
            busy_m[exp_resp] = 1'b1;
            e.due = cyc + LAT;
            e.tag = exp_resp;
            if (c == BUS_STORE) begin
                mem_m[idx] = d;
                e.data = d;
            end else begin
                e.data = mem_m.exists(idx) ? mem_m[idx] : 64'd0;
            end
            sb.push_back(e);
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(BUS_NONE, 32'h0, 64'h0, 1'b0, 4'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) busy_m[i] = 1'b0;

        @(negedge clock);
        cmd = BUS_LOAD;
        #1;
        check("reset_resp", 64'(resp), 64'd0);
        check("reset_tag", 64'(ctag), 64'd0);
        check("reset_data", cdata, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_cycle(BUS_STORE, 32'h40,  DA, 1'b0, 4'd0);
        run_cycle(BUS_STORE, 32'h100, DB, 1'b0, 4'd0);
        run_cycle(BUS_STORE, 32'h200, DC, 1'b0, 4'd0);
        idle(LAT + 2);

        add_vec(BUS_LOAD,  32'h40,        64'h0, 4'd1);
        for (int i = 0; i < 6; i++) add_vec(BUS_NONE, 32'h0, 64'h0, 4'd0);
        add_vec(BUS_STORE, 32'h100,       DD,    4'd1);
        add_vec(BUS_LOAD,  32'h100,       64'h0, 4'd2);
        add_vec(BUS_LOAD,  32'h0001_0045, 64'h0, 4'd3);
        add_vec(BUS_LOAD,  32'h200,       64'h0, 4'd4);
        add_vec(BUS_LOAD,  32'h40,        64'h0, 4'd0);
        add_vec(BUS_LOAD,  32'h40,        64'h0, 4'd0);
        add_vec(BUS_LOAD,  32'h40,        64'h0, 4'd0);
        add_vec(BUS_LOAD,  32'h40,        64'h0, 4'd1);
        add_vec(BUS_LOAD,  32'h100,       64'h0, 4'd2);
        add_vec(BUS_LOAD,  32'h40,        64'h0, 4'd3);
        add_vec(BUS_NONE,  32'h0,         64'h0, 4'd0);
        foreach (tbl[i]) run_cycle(tbl[i].cmd, tbl[i].addr, tbl[i].data, 1'b1, tbl[i].resp);
        idle(LAT + 2);

        for (int i = 0; i < 20; i++) begin
            case (i % 3)
                0:       run_cycle(BUS_LOAD, 32'h40,  64'h0, 1'b0, 4'd0);
                1:       run_cycle(BUS_LOAD, 32'h100, 64'h0, 1'b0, 4'd0);
                default: run_cycle(BUS_LOAD, 32'h200, 64'h0, 1'b0, 4'd0);
            endcase
        end
        idle(LAT + 2);

        for (int i = 0; i < 3; i++) run_cycle(BUS_LOAD, 32'h40, 64'h0, 1'b0, 4'd0);
        idle(LAT - 3);
        cmd = BUS_NONE;
        #1;
        check("pre_reset_tag", 64'(ctag), (sb.size() != 0) ? 64'(sb[0].tag) : 64'hFFFF);
        reset_n = 1'b0;
        cmd = BUS_LOAD;
        #1;
        check("midreset_tag", 64'(ctag), 64'd0);
        check("midreset_data", cdata, 64'd0);
        check("midreset_resp", 64'(resp), 64'd0);
        sb.delete();
        for (int i = 0; i < 16; i++) busy_m[i] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #1;
            check("held_reset_tag", 64'(ctag), 64'd0);
            check("held_reset_resp", 64'(resp), 64'd0);
            cyc++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        run_cycle(BUS_LOAD, 32'h100, 64'h0, 1'b1, 4'd1);
        idle(LAT + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
